// File: rtl/expr_eval_if.sv
// Character-stream bus for expr_eval: input byte with valid/restart, plus
// the running result and status flags coming back.
interface expr_eval_if #(
  parameter int WIDTH = 16
);
  logic [7:0]       in;
  logic             in_valid;
  logic             restart;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             err;
  logic             ovf;

  modport master (output in, in_valid, restart, input result, done, err, ovf);
  modport slave  (input in, in_valid, restart, output result, done, err, ovf);
endinterface

// File: rtl/expr_eval.sv
// Incremental evaluator for single-digit "+"/"*" expressions with "*" precedence.
// Define EXPR_EVAL_SAT_EN for saturating arithmetic with a sticky ovf flag.
module expr_eval #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        clr_n,
  expr_eval_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, NUM, OP, ERR} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sum, sum_nx;
  logic [WIDTH-1:0] term, term_nx;
  logic [WIDTH-1:0] result, result_nx;
  logic             mul, mul_nx;
  logic             err, err_nx;
  logic             ovf, ovf_nx;

  logic             is_dig, is_plus, is_star;
  logic [3:0]       d;
  logic [WIDTH-1:0] dz;
  logic [WIDTH:0]   term_n, res_n, sum_n;

  // Top bit of each helper's return value flags a saturation event.
  function automatic logic [WIDTH:0] add_op(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
`ifdef EXPR_EVAL_SAT_EN
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[WIDTH]) return {1'b1, {WIDTH{1'b1}}};
    return s;
`else
    return {1'b0, a + b};
`endif
  endfunction

  function automatic logic [WIDTH:0] mul_op(input logic [WIDTH-1:0] a,
                                            input logic [3:0]       b);
`ifdef EXPR_EVAL_SAT_EN
    logic [WIDTH+3:0] p;
    p = {4'b0, a} * {{WIDTH{1'b0}}, b};
    if (|p[WIDTH+3:WIDTH]) return {1'b1, {WIDTH{1'b1}}};
    return {1'b0, p[WIDTH-1:0]};
`else
    return {1'b0, a * {{(WIDTH-4){1'b0}}, b}};
`endif
  endfunction

  // ASCII '0'..'9' is 0x30..0x39, so the low nibble is the digit value.
  assign is_dig  = (bus.in >= 8'h30) && (bus.in <= 8'h39);
  assign is_plus = (bus.in == 8'h2B);
  assign is_star = (bus.in == 8'h2A);
  assign d       = bus.in[3:0];
  assign dz      = {{(WIDTH-4){1'b0}}, d};

  assign term_n  = mul ? mul_op(term, d) : {1'b0, dz};
  assign res_n   = add_op(sum, term_n[WIDTH-1:0]);
  assign sum_n   = add_op(sum, term);

  always_comb begin
    state_nx  = state;
    sum_nx    = sum;
    term_nx   = term;
    mul_nx    = mul;
    result_nx = result;
    err_nx    = err;
    ovf_nx    = ovf;
    if (bus.restart) begin
      state_nx  = IDLE;
      sum_nx    = '0;
      term_nx   = '0;
      mul_nx    = 1'b0;
      result_nx = '0;
      err_nx    = 1'b0;
      ovf_nx    = 1'b0;
    end else if (bus.in_valid) begin
      case (state)
        IDLE: begin
          if (is_dig) begin
            state_nx  = NUM;
            sum_nx    = '0;
            term_nx   = dz;
            result_nx = dz;
          end else begin
            state_nx = ERR;
            err_nx   = 1'b1;
          end
        end
        NUM: begin
          if (is_plus) begin
            state_nx = OP;
            sum_nx   = sum_n[WIDTH-1:0];
            mul_nx   = 1'b0;
            ovf_nx   = ovf | sum_n[WIDTH];
          end else if (is_star) begin
            state_nx = OP;
            mul_nx   = 1'b1;
          end else begin
            state_nx = ERR;
            err_nx   = 1'b1;
          end
        end
        OP: begin
          if (is_dig) begin
            state_nx  = NUM;
            term_nx   = term_n[WIDTH-1:0];
            result_nx = res_n[WIDTH-1:0];
            ovf_nx    = ovf | term_n[WIDTH] | res_n[WIDTH];
          end else begin
            state_nx = ERR;
            err_nx   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= IDLE;
      sum    <= '0;
      term   <= '0;
      mul    <= 1'b0;
      result <= '0;
      err    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_nx;
      sum    <= sum_nx;
      term   <= term_nx;
      mul    <= mul_nx;
      result <= result_nx;
      err    <= err_nx;
      ovf    <= ovf_nx;
    end
  end

  assign bus.result = result;
  assign bus.done   = (state == NUM);
  assign bus.err    = err;
`ifdef EXPR_EVAL_SAT_EN
  assign bus.ovf    = ovf;
`else
  assign bus.ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_expr_eval.sv
// Randomized and directed bench for expr_eval; reference model re-evaluates
// the accepted character prefix from scratch after every digit.
module tb_expr_eval;

  localparam int     W    = 8;
  localparam longint MAXV = (longint'(1) << W) - 1;
`ifdef EXPR_EVAL_SAT_EN
  localparam bit     SAT  = 1'b1;
`else
  localparam bit     SAT  = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int   vec = 0;
  int   miss = 0;

  expr_eval_if #(.WIDTH(W)) bus ();
  expr_eval #(.WIDTH(W)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: the accepted characters of the current expression.
  logic [7:0] q[$];
  bit         m_err;
  bit         m_ovf;
  longint     m_res;

  function automatic longint f_add(input longint a, input longint b, inout bit o);
    longint s;
    s = a + b;
    if (SAT && s > MAXV) begin o = 1'b1; return MAXV; end
    return s % (MAXV + 1);
  endfunction

  function automatic longint f_mul(input longint a, input longint b, inout bit o);
    longint p;
    p = a * b;
    if (SAT && p > MAXV) begin o = 1'b1; return MAXV; end
    return p % (MAXV + 1);
  endfunction

  function automatic void m_eval(output longint r, inout bit o);
    longint sum, term;
    bit     pend_mul;
    sum = 0; term = 0; pend_mul = 1'b0;
    foreach (q[i]) begin
      if (q[i] == "+") begin
        sum = f_add(sum, term, o);
        pend_mul = 1'b0;
      end else if (q[i] == "*") begin
        pend_mul = 1'b1;
      end else begin
        term = pend_mul ? f_mul(term, longint'(q[i]) - 48, o) : longint'(q[i]) - 48;
      end
    end
    r = f_add(sum, term, o);
  endfunction

  function automatic void m_clear();
    q.delete();
    m_err = 1'b0;
    m_ovf = 1'b0;
    m_res = 0;
  endfunction

  function automatic bit m_done();
    if (m_err || q.size() == 0) return 1'b0;
    return (q[q.size()-1] != "+") && (q[q.size()-1] != "*");
  endfunction

  task automatic m_apply(input logic [7:0] c, input bit v, input bit rs);
    bit     dig, op, need_dig, o;
    longint r;
    dig = (c >= "0") && (c <= "9");
    op  = (c == "+") || (c == "*");
    if (rs) begin
      m_clear();
    end else if (v && !m_err) begin
      need_dig = (q.size() == 0) ? 1'b1 : ((q[q.size()-1] == "+") || (q[q.size()-1] == "*"));
      if (need_dig ? dig : op) begin
        q.push_back(c);
        if (dig) begin
          o = 1'b0;
          m_eval(r, o);
          m_res = r;
          m_ovf = m_ovf | o;
        end
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic step(input logic [7:0] c, input bit v, input bit rs);
    @(negedge clk);
    bus.in = c; bus.in_valid = v; bus.restart = rs;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.restart = 1'b0;
    m_apply(c, v, rs);
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) step(s[i], 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    bus.in = 8'h00; bus.in_valid = 1'b0; bus.restart = 1'b0;
    clr_n = 1'b0;
    m_clear();
    #12;
    vec++; if (bus.result !== 8'd0) begin miss++; $display("FAIL reset_result got %0d want 0", bus.result); end
    vec++; if (bus.done !== 1'b0)   begin miss++; $display("FAIL reset_done got %b want 0", bus.done); end
    vec++; if (bus.err !== 1'b0)    begin miss++; $display("FAIL reset_err got %b want 0", bus.err); end
    vec++; if (bus.ovf !== 1'b0)    begin miss++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_precedence();
    string s;
    int    er[5];
    bit    ed[5];
    s = "1+2*3";
    er = '{1, 1, 3, 3, 7};
    ed = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      step(s[i], 1'b1, 1'b0);
      vec++; if (bus.result !== er[i][W-1:0]) begin miss++; $display("FAIL prec_result[%0d] got %0d want %0d", i, bus.result, er[i]); end
      vec++; if (bus.done !== ed[i]) begin miss++; $display("FAIL prec_done[%0d] got %b want %b", i, bus.done, ed[i]); end
      vec++; if (bus.err !== 1'b0) begin miss++; $display("FAIL prec_err[%0d] got %b want 0", i, bus.err); end
    end
  endtask

  task automatic test_chained();
    step(8'h00, 1'b0, 1'b1);
    feed("2*3*4+5");
    vec++; if (bus.result !== 8'd29) begin miss++; $display("FAIL chain_result got %0d want 29", bus.result); end
    vec++; if (bus.done !== 1'b1)    begin miss++; $display("FAIL chain_done got %b want 1", bus.done); end
  endtask

  task automatic test_syntax_error();
    step(8'h00, 1'b0, 1'b1);
    feed("1++");
    vec++; if (bus.err !== 1'b1)    begin miss++; $display("FAIL synerr_err got %b want 1", bus.err); end
    vec++; if (bus.done !== 1'b0)   begin miss++; $display("FAIL synerr_done got %b want 0", bus.done); end
    vec++; if (bus.result !== 8'd1) begin miss++; $display("FAIL synerr_result got %0d want 1", bus.result); end
    feed("3");
    vec++; if (bus.result !== 8'd1 || bus.err !== 1'b1 || bus.done !== 1'b0)
      begin miss++; $display("FAIL synerr_absorb got r=%0d e=%b d=%b want r=1 e=1 d=0", bus.result, bus.err, bus.done); end
    step(8'h00, 1'b0, 1'b1);
    feed("4");
    vec++; if (bus.result !== 8'd4) begin miss++; $display("FAIL synerr_restart_result got %0d want 4", bus.result); end
    vec++; if (bus.err !== 1'b0)    begin miss++; $display("FAIL synerr_restart_err got %b want 0", bus.err); end
  endtask

  task automatic test_overflow();
    step(8'h00, 1'b0, 1'b1);
    feed("9*9*9*9");
`ifdef EXPR_EVAL_SAT_EN
    vec++; if (bus.result !== 8'd255) begin miss++; $display("FAIL ovf_result got %0d want 255", bus.result); end
    vec++; if (bus.ovf !== 1'b1)      begin miss++; $display("FAIL ovf_flag got %b want 1", bus.ovf); end
`else
    vec++; if (bus.result !== 8'd161) begin miss++; $display("FAIL ovf_result got %0d want 161", bus.result); end
    vec++; if (bus.ovf !== 1'b0)      begin miss++; $display("FAIL ovf_flag got %b want 0", bus.ovf); end
`endif
  endtask

  task automatic test_gapped();
    step(8'h00, 1'b0, 1'b1);
    feed("5");
    for (int i = 0; i < 3; i++) begin
      step("9", 1'b0, 1'b0);
      vec++; if (bus.result !== 8'd5 || bus.done !== 1'b1)
        begin miss++; $display("FAIL gap_hold[%0d] got r=%0d d=%b want r=5 d=1", i, bus.result, bus.done); end
    end
    feed("*0");
    vec++; if (bus.result !== 8'd0) begin miss++; $display("FAIL gap_result got %0d want 0", bus.result); end
    vec++; if (bus.done !== 1'b1)   begin miss++; $display("FAIL gap_done got %b want 1", bus.done); end
  endtask

  task automatic test_async_reset();
    step(8'h00, 1'b0, 1'b1);
    feed("7+");
    #2 clr_n = 1'b0;
    #1;
    vec++; if (bus.result !== 8'd0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.ovf !== 1'b0)
      begin miss++; $display("FAIL areset_outputs got r=%0d d=%b e=%b o=%b want all 0", bus.result, bus.done, bus.err, bus.ovf); end
    clr_n = 1'b1;
    m_clear();
    feed("8");
    vec++; if (bus.result !== 8'd8) begin miss++; $display("FAIL areset_result got %0d want 8", bus.result); end
    step("5", 1'b1, 1'b1);
    vec++; if (bus.result !== 8'd0 || bus.done !== 1'b0)
      begin miss++; $display("FAIL restart_drop got r=%0d d=%b want r=0 d=0", bus.result, bus.done); end
    feed("3");
    vec++; if (bus.result !== 8'd3 || bus.done !== 1'b1 || bus.err !== 1'b0)
      begin miss++; $display("FAIL restart_idle got r=%0d d=%b e=%b want r=3 d=1 e=0", bus.result, bus.done, bus.err); end
  endtask

  task automatic test_random();
    logic [7:0] c;
    bit         v, rs;
    int         pick;
    step(8'h00, 1'b0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      rs   = ($urandom_range(0, 24) == 0);
      v    = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 9);
      if (pick < 6)      c = 8'h30 + 8'($urandom_range(0, 9));
      else if (pick < 9) c = (pick == 6) ? 8'h2B : 8'h2A;
      else               c = 8'($urandom_range(0, 255));
      step(c, v, rs);
      vec++; if (bus.result !== m_res[W-1:0])
        begin miss++; $display("FAIL rand_result[%0d] got %0d want %0d", n, bus.result, m_res); end
      vec++; if (bus.done !== m_done())
        begin miss++; $display("FAIL rand_done[%0d] got %b want %b", n, bus.done, m_done()); end
      vec++; if (bus.err !== m_err)
        begin miss++; $display("FAIL rand_err[%0d] got %b want %b", n, bus.err, m_err); end
      vec++; if (bus.ovf !== m_ovf)
        begin miss++; $display("FAIL rand_ovf[%0d] got %b want %b", n, bus.ovf, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_precedence();
    test_chained();
    test_syntax_error();
    test_overflow();
    test_gapped();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/expr_eval.md
# expr_eval

Downstream consumer of the character-stream expression recognizer. Takes the same 8-bit ASCII stream of single-digit operands separated by `+` or `*` and evaluates it incrementally with standard precedence (`*` before `+`). After every accepted character it reports the running value of the expression and whether the prefix seen so far is a complete legal expression. It sits after the recognizer in the expression-processing path and supplies the numeric result to the display/checker stage.

## Interface
- `WIDTH`, 16, width of the result and of the internal accumulators (≥ 8).
- `clk` input 1: single clock, rising edge.
- `clr_n` input 1: reset, asynchronous, active-low.
- `in` input 8: ASCII character.
- `in_valid` input 1: `in` is consumed on a rising edge while high.
- `restart` input 1: synchronous start of a new expression.
- `result` output WIDTH: running value; registered.
- `done` output 1: high when the prefix so far is legal and ends in a digit.
- `err` output 1: sticky syntax error.
- `ovf` output 1: sticky overflow flag; always 0 unless `EXPR_EVAL_SAT_EN` is defined.

## Operation
- Registers: `state`, `sum` (WIDTH bits), `term` (WIDTH bits), `mul` (1 bit), and the outputs.
- Digit `d` is `in - "0"` for `in` in `"0"`..`"9"`. The operators are `"+"` and `"*"`. Any other byte is illegal.
- States:
  - IDLE: expects the first digit.
  - NUM: the last character was a digit.
  - OP: the last character was an operator.
  - ERR: absorbing.
- Transitions, only on an accepted character (`in_valid=1`, `restart=0`):
  - IDLE + digit → NUM: `sum<=0`, `term<=d`, `result<=d`.
  - NUM + `+` → OP: `sum<=sum+term`, `mul<=0`.
  - NUM + `*` → OP: `mul<=1`.
  - OP + digit → NUM:
    - `term_n = mul ? term*d : d`.
    - `term<=term_n`.
    - `result<=sum+term_n`.
  - IDLE or OP + operator/illegal, NUM + digit/illegal → ERR, `err<=1`.
  - ERR: all inputs ignored until `restart` or reset.
- `done` is 1 exactly when the state is NUM.
- `result` changes only on a digit-accepting transition. Operators and errors leave it unchanged.
- Arithmetic wraps modulo 2^WIDTH by default. Multiply is WIDTH×4 bits, truncated to WIDTH bits.
- `restart=1` has priority:
  - Next state is IDLE.
  - `sum`, `term`, `mul`, `result`, `err`, `ovf` all clear.
  - `in` is ignored that cycle, even if `in_valid=1`.
- `in_valid=0` holds all state.

## Timing
- Reset (`clr_n=0`) takes effect immediately, with no clock needed:
  - state=IDLE.
  - `result=0`, `done=0`, `err=0`, `ovf=0`.
  - `sum=0`, `term=0`, `mul=0`.
- Deasserting `clr_n` mid-expression discards all progress. The next character is treated as the first.
- Latency is 1: outputs reflect character k after the rising edge that accepts it. No combinational path runs from inputs to outputs.
- Throughput is one character per cycle. There is no backpressure, so the block is always ready.
- Back-to-back expressions: assert `restart` for one cycle between them. Stream from the next cycle onward.

## Configuration
- Macro: `EXPR_EVAL_SAT_EN`.
- When defined:
  - Every add and multiply saturates to 2^WIDTH−1.
  - Any saturating operation sets `ovf<=1`. It stays set until `restart` or reset.
  - Saturation is evaluated per operation, on `sum+term`, `term*d`, and `sum+term_n`.
- When undefined:
  - Wrap-around arithmetic.
  - `ovf` is tied to 0.

## Test plan
- Precedence: reset; feed `"1"`,`"+"`,`"2"`,`"*"`,`"3"` back to back.
  - `result` after each edge: 1,1,3,3,7.
  - `done`: 1,0,1,0,1.
  - `err`=0 throughout.
- Chained terms: feed `"2*3*4+5"` → final `result`=29, `done`=1.
- Syntax error: feed `"1"`,`"+"`,`"+"`.
  - `err`=1 and `done`=0 from the third edge.
  - `result` stays 1.
  - Further `"3"` changes nothing.
  - `restart` then `"4"` → `result`=4, `err`=0.
- Overflow with WIDTH=8, feeding `"9*9*9*9"`:
  - Without macro: `result`=161, `ovf`=0.
  - With `EXPR_EVAL_SAT_EN`: `result`=255, `ovf`=1.
- Gapped input: `"5"`, `in_valid`=0 for 3 cycles, `"*"`, `"0"` → outputs hold during the gap; final `result`=0, `done`=1.
- Async reset mid-expression: after `"7+"`, pulse `clr_n` low between clock edges.
  - All outputs read 0 before the next edge.
  - `"8"` then yields `result`=8.
  - `restart` and `in_valid` high in the same cycle: the char is dropped and the state is IDLE.
